// File: rtl/lvt_multiport_ram.sv
// Multi-port RAM (NW write / NR read) built from 1W/1R banks steered by a Live Value Table.
// Optional write-to-read bypass is enabled by defining LVT_RAM_BYPASS_EN.
module lvt_multiport_ram #(
  parameter int NW = 2,
  parameter int NR = 2,
  parameter int DW = 32,
  parameter int AW = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*DW-1:0] wr_data,
  input  logic [NR-1:0]    rd_en,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR*DW-1:0] rd_data,
  output logic [NR-1:0]    rd_valid,
  output logic             init_busy,
  output logic             wr_conflict
);

  localparam int DEPTH = 2 ** AW;
  localparam int LW    = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    sweep_q, sweep_d;
  logic             init_busy_q, init_busy_d;
  logic             wr_conflict_q, wr_conflict_d;
  logic [NR-1:0]    rd_valid_q, rd_valid_d;
  logic [NR*DW-1:0] rd_data_q, rd_data_d;

  logic [DW-1:0] bank_mem [NW][NR][DEPTH];
  logic [LW-1:0] lvt_mem  [DEPTH];

  logic [NW-1:0] wr_win;
  logic          conflict;
  logic [LW-1:0] lvt_sel [NR];
  logic [DW-1:0] rd_word [NR];

  // A port wins unless a higher-indexed enabled port targets the same address.
  always_comb begin
    wr_win   = '0;
    conflict = 1'b0;
    for (int p = 0; p < NW; p++) begin
      wr_win[p] = wr_en[p] && (state_q == ST_RUN);
      for (int q = p + 1; q < NW; q++) begin
        if (wr_en[p] && wr_en[q] && (wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW])) begin
          wr_win[p] = 1'b0;
          conflict  = 1'b1;
        end
      end
    end
  end

  // Read mux: the LVT names the write port whose bank holds the live value.
  always_comb begin
    for (int r = 0; r < NR; r++) begin
      lvt_sel[r] = lvt_mem[rd_addr[r*AW +: AW]];
      rd_word[r] = bank_mem[lvt_sel[r]][r][rd_addr[r*AW +: AW]];
`ifdef LVT_RAM_BYPASS_EN
      for (int p = 0; p < NW; p++) begin
        if (wr_win[p] && (wr_addr[p*AW +: AW] == rd_addr[r*AW +: AW])) begin
          rd_word[r] = wr_data[p*DW +: DW];
        end
      end
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    init_busy_d   = init_busy_q;
    wr_conflict_d = 1'b0;
    rd_valid_d    = '0;
    rd_data_d     = rd_data_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == {AW{1'b1}}) begin
        state_d     = ST_RUN;
        init_busy_d = 1'b0;
      end
    end else begin
      wr_conflict_d = conflict;
      rd_valid_d    = rd_en;
      for (int r = 0; r < NR; r++) begin
        if (rd_en[r]) rd_data_d[r*DW +: DW] = rd_word[r];
      end
    end
  end

  // NOTE: all state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      sweep_q       <= '0;
      init_busy_q   <= 1'b1;
      wr_conflict_q <= 1'b0;
      rd_valid_q    <= '0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      sweep_q       <= sweep_d;
      init_busy_q   <= init_busy_d;
      wr_conflict_q <= wr_conflict_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // NOTE: the storage arrays carry no reset; the INIT sweep clears them one address per cycle.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      for (int p = 0; p < NW; p++) begin
        for (int r = 0; r < NR; r++) bank_mem[p][r][sweep_q] <= '0;
      end
      lvt_mem[sweep_q] <= '0;
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (wr_win[p]) begin
          for (int r = 0; r < NR; r++) bank_mem[p][r][wr_addr[p*AW +: AW]] <= wr_data[p*DW +: DW];
          lvt_mem[wr_addr[p*AW +: AW]] <= LW'(p);
        end
      end
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign init_busy   = init_busy_q;
  assign wr_conflict = wr_conflict_q;

endmodule

// File: doc/lvt_multiport_ram.md
# lvt_multiport_ram

Parametrised multi-port RAM built from 1W/1R banks plus a Live Value Table (LVT). Supports NW independent write ports and NR independent read ports on a shared DEPTH-entry address space. It is the general successor to the fixed 2W/1R, 32-bit, 128-deep LVT memory, and sits between the datapath register files / scratchpads and their producers. It adds a post-reset clearing sweep, a deterministic write-conflict policy with a conflict flag, per-port read-valid, and optional write-to-read bypass.

## Interface
- NW, 2, number of write ports (1..4)
- NR, 2, number of read ports (1..4)
- DW, 32, data width in bits
- AW, 7, address width; DEPTH = 2**AW
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  NW  per-port write enable
- wr_addr  in  NW*AW  write addresses, port p at [p*AW +: AW]
- wr_data  in  NW*DW  write data, port p at [p*DW +: DW]
- rd_en  in  NR  per-port read enable
- rd_addr  in  NR*AW  read addresses, port r at [r*AW +: AW]
- rd_data  out  NR*DW  registered read data, port r at [r*DW +: DW]
- rd_valid  out  NR  rd_data for port r is valid this cycle
- init_busy  out  1  clearing sweep in progress; all requests ignored
- wr_conflict  out  1  one-cycle pulse: two or more enabled write ports hit the same address

## Operation
- Storage: NW*NR banks, bank[p][r] written only by write port p and read only by read port r. The LVT is DEPTH entries of clog2(NW) bits (1 bit minimum).
- FSM states: INIT, RUN.
- INIT:
  - Entered on rst_n low, regardless of prior state.
  - An AW-bit sweep counter starts at 0 and writes 0 to every bank and to the LVT entry at the counter address.
  - Advances one address per cycle.
  - After address DEPTH-1 the FSM goes to RUN.
- RUN, write:
  - Each enabled port p writes wr_data[p] into bank[p][*] at wr_addr[p], and sets LVT[wr_addr[p]] = p.
- RUN, write conflict:
  - When two or more enabled ports share an address, the highest-indexed port wins. Only that port's banks and the LVT entry are updated; losing ports write nothing.
  - wr_conflict is asserted the following cycle.
- RUN, read:
  - Port r reads LVT[rd_addr[r]] and bank[*][r] at rd_addr[r].
  - rd_data[r] is bank[LVT][r].
- Read of a location never written since INIT returns 0.
- Requests during INIT are dropped silently; no side effects.

## Timing
- Reset values:
  - rd_data = 0, rd_valid = 0, wr_conflict = 0.
  - init_busy = 1, state = INIT, sweep counter = 0.
- INIT lasts exactly DEPTH cycles after rst_n rises.
- init_busy falls on the edge that completes address DEPTH-1. The first accepted request comes in the cycle after that, when init_busy reads 0.
- rst_n asserted mid-INIT or mid-RUN aborts everything. The sweep restarts from 0.
- Write latency: a write at edge t is visible to a read issued in cycle t+1.
- Read latency: 1 cycle. A read with rd_en[r]=1 in cycle t gives rd_data[r] with rd_valid[r]=1 after edge t.
- With rd_en[r]=0: rd_valid[r]=0 and rd_data[r] holds its last value.
- Same-cycle read and write to one address: behaviour depends on LVT_RAM_BYPASS_EN (see Configuration).
- wr_conflict is a registered pulse, high for one cycle per conflicting cycle.

## Configuration
- Macro: LVT_RAM_BYPASS_EN.
- Defined: a read in cycle t whose address matches an enabled write in cycle t returns that write's data at t+1. If several writes match, it returns the winning (highest-index) port's data. Adds a comparator and mux per read port.
- Undefined: the same read returns the pre-write contents (read-first). The new value is visible from cycle t+1 reads.

## Test plan
- Reset then idle: rst_n low 3 cycles, then high → init_busy=1 for exactly 128 cycles (AW=7). Reads of addresses 0, 64 and 127 then return 0 with rd_valid=1 one cycle after rd_en.
- Independent writes: port0 writes 0xDEADBEEF to 0x05 and port1 writes 0x12345678 to 0x06 in the same cycle. The next cycle, read0 reads 0x05 and read1 reads 0x06 → 0xDEADBEEF and 0x12345678.
- Overwrite tracking: port0 writes 0xAAAA0000 to 0x10, then port1 writes 0x5555FFFF to 0x10, then port0 writes 0x0000000F to 0x10. Reads after each write return 0xAAAA0000, 0x5555FFFF, 0x0000000F on both read ports.
- Conflict: port0 and port1 both write 0x20 in one cycle with 0x1 and 0x2 → wr_conflict=1 in the next cycle only. A read of 0x20 returns 0x2.
- Read-during-write: 0x30 holds 0x11, and in one cycle port1 writes 0x22 to 0x30 while read0 reads 0x30. Result is 0x11 without the macro, 0x22 with LVT_RAM_BYPASS_EN.
- Reset mid-operation: write 0x77 to 0x40, then pulse rst_n low at sweep address 50 of the following INIT → sweep restarts at 0 and takes a full 128 cycles. A read of 0x40 afterwards returns 0. Requests issued during INIT have no effect.
